// File: rtl/txt_pkg.sv
// rtl/txt_pkg.sv - shared constants for the text-mode renderer
package txt_pkg;
  localparam int CODE_LSB      = 0;
  localparam int CODE_W        = 8;
  localparam int FG_LSB        = 8;
  localparam int BG_LSB        = 12;
  localparam int PAL_W         = 4;
  localparam int GLYPH_W       = 8;
  localparam int BLINK_DEFAULT = 32;
endpackage

// File: rtl/txt_blink.sv
// rtl/txt_blink.sv - frame counter and cursor blink phase
module txt_blink
  import txt_pkg::*;
#(
  parameter int BLINK_FRAMES = BLINK_DEFAULT
) (
  input  logic clk,
  input  logic clr,
  input  logic frame_start,
  output logic blink_phase
);
  localparam int CNT_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(BLINK_FRAMES - 1);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      count       <= '0;
      blink_phase <= 1'b1;
    end else if (frame_start) begin
      if (count == LAST) begin
        count       <= '0;
        blink_phase <= ~blink_phase;
      end else begin
        count <= count + 1'b1;
      end
    end
  end
endmodule

// File: rtl/txt_render.sv
// rtl/txt_render.sv - three-stage character-cell text renderer
module txt_render
  import txt_pkg::*;
#(
  parameter int COLS         = 40,
  parameter int ROWS         = 30,
  parameter int FONT_H       = 16,
  parameter int BLINK_FRAMES = BLINK_DEFAULT,
  parameter int ADDR_W       = 12
) (
  input  logic               clk,
  input  logic               clr,
  input  logic [9:0]         pixh,
  input  logic [9:0]         pixv,
  input  logic               active,
  input  logic               hsync_in,
  input  logic               vsync_in,
  output logic [ADDR_W-1:0]  dis_addr,
  output logic               dis_mem_en,
  input  logic [15:0]        dis_dat,
  output logic [11:0]        font_addr,
  output logic               font_mem_en,
  input  logic [GLYPH_W-1:0] font_dat,
  input  logic [7:0]         cursor_col,
  input  logic [7:0]         cursor_row,
  input  logic               cursor_en,
  output logic [PAL_W-1:0]   out_color,
  output logic               out_de,
  output logic               out_hsync,
  output logic               out_vsync
);
  localparam int         FROW_SH   = (FONT_H == 16) ? 4 : 3;
  localparam logic [3:0] FROW_MASK = 4'(FONT_H - 1);
  localparam logic [3:0] CUR_TOP   = 4'(FONT_H - 2);

  logic [6:0]       col_c;
  logic [2:0]       scol_c;
  logic [9:0]       row_c;
  logic [3:0]       frow_c;
  logic             in_grid, fetch_c, hit_c, frame_start, blink_phase;
  logic [2:0]       scol1, scol2, bit_idx;
  logic [3:0]       frow1;
  logic             v1, v2, hit1;
  logic [2:0]       de_d, hs_d, vs_d;
  logic [PAL_W-1:0] fg_c, bg_c, fg2, bg2;

  // Stage 0: cell decode; memory address is combinational so data lands at t+1
  assign col_c       = pixh[9:3];
  assign scol_c      = pixh[2:0];
  assign row_c       = pixv >> FROW_SH;
  assign frow_c      = pixv[3:0] & FROW_MASK;
  assign in_grid     = ({3'b000, col_c} < 10'(COLS)) && (row_c < 10'(ROWS));
  assign fetch_c     = active && in_grid;
  assign hit_c       = fetch_c && cursor_en && blink_phase &&
                       ({1'b0, col_c} == cursor_col) && (row_c == {2'b00, cursor_row}) &&
                       (frow_c >= CUR_TOP);
  assign frame_start = (pixh == 10'd0) && (pixv == 10'd0);
  assign dis_addr    = clr ? '0 : ADDR_W'(row_c) * ADDR_W'(COLS) + ADDR_W'(col_c);
  assign dis_mem_en  = fetch_c && !clr;

  // Stage 1: glyph line address from the returned cell word
  assign font_addr   = clr ? '0 : {dis_dat[CODE_LSB +: CODE_W], frow1};
  assign font_mem_en = v1;
  assign fg_c        = dis_dat[FG_LSB +: PAL_W];
  assign bg_c        = dis_dat[BG_LSB +: PAL_W];
  assign bit_idx     = 3'(GLYPH_W - 1) - scol2;

  assign out_de    = de_d[2];
  assign out_hsync = hs_d[2];
  assign out_vsync = vs_d[2];

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      scol1     <= '0;
      scol2     <= '0;
      frow1     <= '0;
      v1        <= 1'b0;
      v2        <= 1'b0;
      hit1      <= 1'b0;
      fg2       <= '0;
      bg2       <= '0;
      de_d      <= '0;
      hs_d      <= '0;
      vs_d      <= '0;
      out_color <= '0;
    end else begin
      scol1     <= scol_c;
      frow1     <= frow_c;
      v1        <= fetch_c;
      hit1      <= hit_c;
      scol2     <= scol1;
      v2        <= v1;
      fg2       <= hit1 ? bg_c : fg_c;
      bg2       <= hit1 ? fg_c : bg_c;
      de_d      <= {de_d[1:0], active};
      hs_d      <= {hs_d[1:0], hsync_in};
      vs_d      <= {vs_d[1:0], vsync_in};
      out_color <= v2 ? (font_dat[bit_idx] ? fg2 : bg2) : '0;
    end
  end

  txt_blink #(.BLINK_FRAMES(BLINK_FRAMES)) u_blink (
    .clk        (clk),
    .clr        (clr),
    .frame_start(frame_start),
    .blink_phase(blink_phase)
  );
endmodule

// File: tb/tb_txt_render.sv
// tb/tb_txt_render.sv - directed self-checking bench for txt_render
module tb_txt_render;
  logic        clk = 1'b0;
  logic        clr;
  logic [9:0]  pixh, pixv;
  logic        active, hsync_in, vsync_in;
  logic [11:0] dis_addr;
  logic        dis_mem_en;
  logic [15:0] dis_dat = '0;
  logic [11:0] font_addr;
  logic        font_mem_en;
  logic [7:0]  font_dat = '0;
  logic [7:0]  cursor_col, cursor_row;
  logic        cursor_en;
  logic [3:0]  out_color;
  logic        out_de, out_hsync, out_vsync;

  int n_chk = 0;
  int n_err = 0;

  logic [15:0] dmem [0:4095];
  logic [7:0]  fmem [0:4095];

  logic [9:0] sh [0:15];
  logic [9:0] sv [0:15];
  logic       sa [0:15];
  logic [3:0] ec [0:15];
  logic       ed [0:15];
  int         n_px;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (dis_mem_en)  dis_dat  <= dmem[dis_addr];
    if (font_mem_en) font_dat <= fmem[font_addr];
  end

  txt_render #(.BLINK_FRAMES(2)) dut (
    .clk(clk), .clr(clr), .pixh(pixh), .pixv(pixv), .active(active),
    .hsync_in(hsync_in), .vsync_in(vsync_in),
    .dis_addr(dis_addr), .dis_mem_en(dis_mem_en), .dis_dat(dis_dat),
    .font_addr(font_addr), .font_mem_en(font_mem_en), .font_dat(font_dat),
    .cursor_col(cursor_col), .cursor_row(cursor_row), .cursor_en(cursor_en),
    .out_color(out_color), .out_de(out_de), .out_hsync(out_hsync), .out_vsync(out_vsync)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [9:0] h, input logic [9:0] v, input logic a);
    pixh = h;
    pixv = v;
    active = a;
  endtask

  task automatic add_px(input logic [9:0] h, input logic [9:0] v, input logic a,
                        input logic [3:0] c, input logic d);
    sh[n_px] = h; sv[n_px] = v; sa[n_px] = a; ec[n_px] = c; ed[n_px] = d;
    n_px++;
  endtask

  task automatic run_stream(input string tag);
    for (int i = 0; i < n_px + 3; i++) begin
      if (i < n_px) drive(sh[i], sv[i], sa[i]);
      else          drive(10'd1000, 10'd1000, 1'b0);
      #1;
      if (i >= 3) begin
        chk($sformatf("%s_color[%0d]", tag, i - 3), 32'(out_color), 32'(ec[i-3]));
        chk($sformatf("%s_de[%0d]", tag, i - 3), 32'(out_de), 32'(ed[i-3]));
      end
      tick();
    end
    n_px = 0;
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) begin
      dmem[i] = 16'h0000;
      fmem[i] = 8'h00;
    end
    dmem[0]    = 16'h1F41;
    dmem[1]    = 16'h2E41;
    dmem[122]  = 16'h5A42;
    dmem[1199] = 16'h2C55;
    fmem[12'h410] = 8'h18;
    fmem[12'h42D] = 8'h80;
    fmem[12'h42E] = 8'h80;
    fmem[12'h42F] = 8'h80;
    n_px = 0;
    cursor_col = 8'd2;
    cursor_row = 8'd3;
    cursor_en  = 1'b1;
    hsync_in = 1'b0;
    vsync_in = 1'b0;

    // reset values while clr is held
    clr = 1'b1;
    drive(10'd8, 10'd0, 1'b1);
    hsync_in = 1'b1;
    tick();
    tick();
    chk("rst_dis_addr", 32'(dis_addr), 32'd0);
    chk("rst_dis_mem_en", 32'(dis_mem_en), 32'd0);
    chk("rst_font_addr", 32'(font_addr), 32'd0);
    chk("rst_font_mem_en", 32'(font_mem_en), 32'd0);
    chk("rst_out_color", 32'(out_color), 32'd0);
    chk("rst_out_de", 32'(out_de), 32'd0);
    chk("rst_out_hsync", 32'(out_hsync), 32'd0);
    chk("rst_out_vsync", 32'(out_vsync), 32'd0);
    chk("rst_blink_phase", 32'(dut.blink_phase), 32'd1);
    hsync_in = 1'b0;
    clr = 1'b0;

    // glyph 'A' line 0 in cell (0,0): fg=F, bg=1
    for (int i = 0; i < 8; i++)
      add_px(10'(i), 10'd0, 1'b1, (i == 3 || i == 4) ? 4'hF : 4'h1, 1'b1);
    run_stream("cell00");

    // last cell of the grid, last fine row
    drive(10'd319, 10'd479, 1'b1);
    #1;
    chk("last_dis_addr", 32'(dis_addr), 32'd1199);
    chk("last_dis_mem_en", 32'(dis_mem_en), 32'd1);
    tick();
    drive(10'd1000, 10'd1000, 1'b0);
    #1;
    chk("last_font_addr", 32'(font_addr), 32'h55F);
    chk("last_font_mem_en", 32'(font_mem_en), 32'd1);
    tick(); tick(); tick();

    // outside the grid while active, and an inactive in-grid pixel
    drive(10'd320, 10'd0, 1'b1);
    #1;
    chk("oob_dis_mem_en", 32'(dis_mem_en), 32'd0);
    add_px(10'd320, 10'd0,   1'b1, 4'h0, 1'b1);
    add_px(10'd0,   10'd480, 1'b1, 4'h0, 1'b1);
    add_px(10'd8,   10'd0,   1'b0, 4'h0, 1'b0);
    add_px(10'd9,   10'd0,   1'b1, 4'h2, 1'b1);
    run_stream("oob");

    // sync delay line
    for (int i = 0; i < 6; i++) begin
      hsync_in = (i == 0);
      vsync_in = (i == 1);
      #1;
      chk($sformatf("hsync[%0d]", i), 32'(out_hsync), 32'(i == 3));
      chk($sformatf("vsync[%0d]", i), 32'(out_vsync), 32'(i == 4));
      tick();
    end

    // cursor blink: frame 0 begins at reset release, later frames at (0,0)
    clr = 1'b1;
    tick();
    clr = 1'b0;
    for (int f = 0; f < 4; f++) begin
      if (f > 0) add_px(10'd0, 10'd0, 1'b1, 4'h1, 1'b1);
      add_px(10'd16, 10'd62, 1'b1, (f < 2) ? 4'h5 : 4'hA, 1'b1);
      add_px(10'd17, 10'd62, 1'b1, (f < 2) ? 4'hA : 4'h5, 1'b1);
      add_px(10'd16, 10'd63, 1'b1, (f < 2) ? 4'h5 : 4'hA, 1'b1);
      add_px(10'd16, 10'd61, 1'b1, 4'hA, 1'b1);
      run_stream($sformatf("cursor_f%0d", f));
    end

    // asynchronous clear mid-line, then recovery on cell (1,0)
    for (int i = 0; i < 4; i++) begin
      drive(10'(8 + i), 10'd0, 1'b1);
      tick();
    end
    drive(10'd12, 10'd0, 1'b1);
    #1;
    chk("pre_clr_color", 32'(out_color), 32'h2);
    chk("pre_clr_de", 32'(out_de), 32'd1);
    chk("pre_clr_dis_addr", 32'(dis_addr), 32'd1);
    chk("pre_clr_blink", 32'(dut.blink_phase), 32'd0);
    clr = 1'b1;
    #1;
    chk("clr_color", 32'(out_color), 32'd0);
    chk("clr_de", 32'(out_de), 32'd0);
    chk("clr_dis_addr", 32'(dis_addr), 32'd0);
    chk("clr_dis_mem_en", 32'(dis_mem_en), 32'd0);
    chk("clr_font_mem_en", 32'(font_mem_en), 32'd0);
    chk("clr_font_addr", 32'(font_addr), 32'd0);
    chk("clr_blink", 32'(dut.blink_phase), 32'd1);
    tick();
    clr = 1'b0;
    for (int i = 0; i < 8; i++)
      add_px(10'(8 + i), 10'd0, 1'b1, (i == 3 || i == 4) ? 4'hE : 4'h2, 1'b1);
    run_stream("resume");

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
